// File: rtl/pref_pkg.sv
// Shared constants, types and the line-alignment helper for the prefetch issue queue.
package pref_pkg;

   localparam int LINE_OFFSET = 6;
   localparam int PKG_ADDR_W  = 64;
   localparam int DROP_CNT_W  = 32;

   typedef logic [PKG_ADDR_W-1:0] line_addr_t;

   function automatic line_addr_t to_line(input line_addr_t addr);
      return {addr[PKG_ADDR_W-1:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
   endfunction

endpackage

// File: rtl/pref_filter.sv
// Recent-line CAM: 3 lookup ports on start-of-cycle state, 3 round-robin insert ports.
// Only built when PREF_FILTER_EN is defined.
`ifdef PREF_FILTER_EN
module pref_filter #(
   parameter int ENTRIES = 16,
   parameter int ADDR_W  = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [2:0][ADDR_W-1:0] look_line,
   output logic [2:0]             hit,
   input  logic [2:0]             ins_valid,
   input  logic [2:0][ADDR_W-1:0] ins_line
);

   localparam int PW = $clog2(ENTRIES);

   logic [ADDR_W-1:0]  ent_line [ENTRIES];
   logic [ENTRIES-1:0] ent_valid;
   logic [PW-1:0]      ptr;
   logic [PW-1:0]      ptr_next;
   logic [2:0][PW-1:0] idx;

   always_comb begin
      hit = '0;
      for (int p = 0; p < 3; p++) begin
         for (int e = 0; e < ENTRIES; e++) begin
            if (ent_valid[e] && ent_line[e] == look_line[p]) hit[p] = 1'b1;
         end
      end
   end

   // Inserts pack densely from the pointer so skipped ports leave no holes.
   always_comb begin
      idx[0]   = ptr;
      idx[1]   = idx[0] + PW'(ins_valid[0]);
      idx[2]   = idx[1] + PW'(ins_valid[1]);
      ptr_next = idx[2] + PW'(ins_valid[2]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_valid <= '0;
         ptr       <= '0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (ins_valid[k]) ent_valid[idx[k]] <= 1'b1;
         end
         ptr <= ptr_next;
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (ins_valid[k]) ent_line[idx[k]] <= ins_line[k];
      end
   end

endmodule
`endif

// File: rtl/pref_queue.sv
// Prefetch issue queue: line-align, dedup, optional recent-line filter (PREF_FILTER_EN),
// FIFO buffering and one valid/ready request per cycle.
module pref_queue
   import pref_pkg::*;
#(
   parameter int DEPTH          = 8,
   parameter int FILTER_ENTRIES = 16,
   parameter int ADDR_W         = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ADDR_W-1:0]         pref_addr1_i,
   input  logic [ADDR_W-1:0]         pref_addr2_i,
   input  logic [ADDR_W-1:0]         pref_addr3_i,
   input  logic                      pref_valid1_i,
   input  logic                      pref_valid2_i,
   input  logic                      pref_valid3_i,
   output logic [ADDR_W-1:0]         req_addr_o,
   output logic                      req_valid_o,
   input  logic                      req_ready_i,
   output logic [$clog2(DEPTH):0]    occupancy_o,
   output logic [DROP_CNT_W-1:0]     drop_cnt_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
       FILTER_ENTRIES < 2 || (FILTER_ENTRIES & (FILTER_ENTRIES - 1)) != 0) begin : g_bad_cfg
      $error("pref_queue: DEPTH and FILTER_ENTRIES must be powers of two >= 2");
   end

   logic [2:0][ADDR_W-1:0] lines;
   logic [2:0]             valid_in;
   logic [2:0]             hit;
   logic [2:0]             keep;
   logic [2:0]             acc;
   logic [2:0][PW-1:0]     wr_idx;
   logic [CW-1:0]          free;
   logic [CW-1:0]          taken;
   logic [1:0]             drop_now;
   logic                   deq;
   logic [DROP_CNT_W:0]    drop_sum;

   logic [ADDR_W-1:0]      mem [DEPTH];
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [CW-1:0]          count;
   logic [DROP_CNT_W-1:0]  drop_cnt;

   assign lines[0] = ADDR_W'(to_line(line_addr_t'(pref_addr1_i)));
   assign lines[1] = ADDR_W'(to_line(line_addr_t'(pref_addr2_i)));
   assign lines[2] = ADDR_W'(to_line(line_addr_t'(pref_addr3_i)));
   assign valid_in = {pref_valid3_i, pref_valid2_i, pref_valid1_i};

`ifdef PREF_FILTER_EN
   pref_filter #(
      .ENTRIES (FILTER_ENTRIES),
      .ADDR_W  (ADDR_W)
   ) u_filter (
      .clk       (clk),
      .rst       (rst),
      .look_line (lines),
      .hit       (hit),
      .ins_valid (acc),
      .ins_line  (lines)
   );
`else
   assign hit = '0;
`endif

   // Space is judged at cycle start; later slots lose first when it runs out.
   always_comb begin
      keep[0]  = valid_in[0] & ~hit[0];
      keep[1]  = valid_in[1] & ~(valid_in[0] && lines[1] == lines[0]) & ~hit[1];
      keep[2]  = valid_in[2] & ~(valid_in[0] && lines[2] == lines[0])
                             & ~(valid_in[1] && lines[2] == lines[1]) & ~hit[2];
      free     = CW'(DEPTH) - count;
      taken    = '0;
      acc      = '0;
      drop_now = 2'd0;
      wr_idx   = '0;
      for (int i = 0; i < 3; i++) begin
         wr_idx[i] = wr_ptr + PW'(taken);
         if (keep[i]) begin
            if (taken < free) begin
               acc[i] = 1'b1;
               taken  = taken + CW'(1);
            end else begin
               drop_now = drop_now + 2'd1;
            end
         end
      end
      deq      = (count != '0) && req_ready_i;
      drop_sum = {1'b0, drop_cnt} + (DROP_CNT_W+1)'(drop_now);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         drop_cnt <= '0;
      end else begin
         wr_ptr   <= wr_ptr + PW'(taken);
         rd_ptr   <= rd_ptr + PW'(deq);
         count    <= count + taken - CW'(deq);
         drop_cnt <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (acc[i]) mem[wr_idx[i]] <= lines[i];
      end
   end

   assign req_valid_o = (count != '0);
   assign req_addr_o  = (count != '0) ? mem[rd_ptr] : '0;
   assign occupancy_o = count;
   assign drop_cnt_o  = drop_cnt;

endmodule

// File: tb/tb_pref_queue.sv
// Directed and randomized checks of pref_queue against a queue-based reference model.
module tb_pref_queue;

   localparam int DEPTH = 8;
   localparam int FE    = 16;
   localparam int AW    = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] cand_addr [3];
   logic          cand_valid [3];
   logic          ready;
   logic [AW-1:0] req_addr_o;
   logic          req_valid_o;
   logic [3:0]    occupancy_o;
   logic [31:0]   drop_cnt_o;

   int tests = 0;
   int fails = 0;

   logic [AW-1:0] mq [$];
   logic [31:0]   m_drop;
   logic [AW-1:0] f_line [FE];
   bit            f_valid [FE];
   int            f_ptr;

   pref_queue #(.DEPTH(DEPTH), .FILTER_ENTRIES(FE), .ADDR_W(AW)) dut (
      .clk           (clk),
      .rst           (rst),
      .pref_addr1_i  (cand_addr[0]),
      .pref_addr2_i  (cand_addr[1]),
      .pref_addr3_i  (cand_addr[2]),
      .pref_valid1_i (cand_valid[0]),
      .pref_valid2_i (cand_valid[1]),
      .pref_valid3_i (cand_valid[2]),
      .req_addr_o    (req_addr_o),
      .req_valid_o   (req_valid_o),
      .req_ready_i   (ready),
      .occupancy_o   (occupancy_o),
      .drop_cnt_o    (drop_cnt_o)
   );

   always #5 clk = ~clk;

   function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
      return a & ~64'h3F;
   endfunction

   task automatic modelReset();
      mq.delete();
      m_drop = 32'd0;
      for (int e = 0; e < FE; e++) f_valid[e] = 1'b0;
      f_ptr = 0;
   endtask

   // One clock of the reference: survivors, capacity cut, pop, push, filter record.
   task automatic modelStep();
      logic [AW-1:0] surv [$];
      logic [AW-1:0] ln;
      bit            dup;
      int            free;
      int            n_acc;
      int unsigned   dropped;
      for (int i = 0; i < 3; i++) begin
         if (cand_valid[i]) begin
            ln  = line_of(cand_addr[i]);
            dup = 1'b0;
            for (int j = 0; j < i; j++)
               if (cand_valid[j] && line_of(cand_addr[j]) == ln) dup = 1'b1;
`ifdef PREF_FILTER_EN
            for (int e = 0; e < FE; e++)
               if (f_valid[e] && f_line[e] == ln) dup = 1'b1;
`endif
            if (!dup) surv.push_back(ln);
         end
      end
      free    = DEPTH - mq.size();
      n_acc   = (surv.size() < free) ? surv.size() : free;
      dropped = surv.size() - n_acc;
      if (m_drop > 32'hFFFF_FFFF - dropped) m_drop = 32'hFFFF_FFFF;
      else m_drop = m_drop + dropped;
      if (mq.size() != 0 && ready) void'(mq.pop_front());
      for (int k = 0; k < n_acc; k++) begin
         mq.push_back(surv[k]);
         f_line[f_ptr]  = surv[k];
         f_valid[f_ptr] = 1'b1;
         f_ptr          = (f_ptr + 1) % FE;
      end
   endtask

   task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp)
      else begin
         fails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [AW-1:0] exp_addr;
      exp_addr = (mq.size() != 0) ? mq[0] : '0;
      checkEq({tag, ".valid"}, 64'(req_valid_o), 64'(mq.size() != 0));
      checkEq({tag, ".addr"},  req_addr_o, exp_addr);
      checkEq({tag, ".occ"},   64'(occupancy_o), 64'(mq.size()));
      checkEq({tag, ".drop"},  64'(drop_cnt_o), 64'(m_drop));
   endtask

   task automatic applyStimulus(input bit v1, input logic [AW-1:0] a1,
                                input bit v2, input logic [AW-1:0] a2,
                                input bit v3, input logic [AW-1:0] a3,
                                input bit rdy, input string tag);
      cand_valid[0] = v1; cand_addr[0] = a1;
      cand_valid[1] = v2; cand_addr[1] = a2;
      cand_valid[2] = v3; cand_addr[2] = a3;
      ready = rdy;
      @(posedge clk);
      #1;
      modelStep();
      checkOutput(tag);
   endtask

   task automatic doReset();
      rst = 1'b1;
      #2;
      modelReset();
      checkOutput("reset");
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cand_valid[i] = 1'b0;
         cand_addr[i]  = '0;
      end
      modelReset();
      #1;
      checkOutput("por");
      #5;
      rst = 1'b0;

      applyStimulus(1, 64'h1039, 0, 0, 0, 0, 1, "single");
      checkEq("single.line", req_addr_o, 64'h1000);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, "single_drain");
      checkEq("single.empty", 64'(req_valid_o), 64'd0);

      applyStimulus(1, 64'h2000, 1, 64'h2010, 1, 64'h2040, 1, "dedup");
      checkEq("dedup.occ", 64'(occupancy_o), 64'd2);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, "dedup_d1");
      checkEq("dedup.second", req_addr_o, 64'h2040);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, "dedup_d2");

      applyStimulus(1, 64'h3000, 0, 0, 0, 0, 0, "filt_a");
      applyStimulus(1, 64'h3000, 0, 0, 0, 0, 0, "filt_b");
`ifdef PREF_FILTER_EN
      checkEq("filt.occ", 64'(occupancy_o), 64'd1);
`else
      checkEq("filt.occ", 64'(occupancy_o), 64'd2);
`endif
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, "filt_drain");

      doReset();
      for (int c = 0; c < 4; c++)
         applyStimulus(1, 64'h10000 + 64'((c*3+0)*64),
                       1, 64'h10000 + 64'((c*3+1)*64) + 64'h5,
                       1, 64'h10000 + 64'((c*3+2)*64) + 64'h3F, 0, "fill");
      checkEq("full.occ", 64'(occupancy_o), 64'd8);
      checkEq("full.drop", 64'(drop_cnt_o), 64'd4);
      checkEq("full.head", req_addr_o, 64'h10000);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, "hold");
      checkEq("hold.head", req_addr_o, 64'h10000);

      applyStimulus(1, 64'h20000, 0, 0, 0, 0, 1, "full_deq");
      checkEq("full_deq.occ", 64'(occupancy_o), 64'd7);
      checkEq("full_deq.drop", 64'(drop_cnt_o), 64'd5);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, "pre_rst1");
      applyStimulus(0, 0, 0, 0, 0, 0, 1, "pre_rst2");
      checkEq("pre_rst.occ", 64'(occupancy_o), 64'd5);

      #3;
      rst = 1'b1;
      #1;
      checkEq("arst.valid", 64'(req_valid_o), 64'd0);
      checkEq("arst.occ", 64'(occupancy_o), 64'd0);
      checkEq("arst.drop", 64'(drop_cnt_o), 64'd0);
      modelReset();
      #2;
      rst = 1'b0;

      for (int n = 0; n < 400; n++) begin
         logic [AW-1:0] ra [3];
         bit            rv [3];
         for (int i = 0; i < 3; i++) begin
            rv[i] = ($urandom_range(0, 3) != 0);
            ra[i] = 64'h4000_0000 + 64'($urandom_range(0, 23) * 64) + 64'($urandom_range(0, 63));
         end
         applyStimulus(rv[0], ra[0], rv[1], ra[1], rv[2], ra[2],
                       ($urandom_range(0, 3) != 0), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
